pc_unit: RTL and testbench

Parametrised program-counter unit for the single-cycle core, replacing the fixed 32-bit PC register. It holds the architectural PC, computes the next PC from sequential, branch, jump, return and exception sources with fixed priority, and supports stall and a configurable reset vector. An optional return-address stack (RAS) records call return addresses and flags return-target mismatches for debug and performance counting.

---
 rtl/pc_pkg.sv | 22 ++
 rtl/ras_stack.sv | 67 ++++++
 rtl/pc_unit.sv | 100 ++++++++++
 tb/tb_pc_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter unit.
// Holds the next-PC source select, the default reset/exception vectors
// and the sequential PC increment.
package pc_pkg;

  // Next-PC source, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    NPC_RST,
    NPC_EXC,
    NPC_HOLD,
    NPC_JMP,
    NPC_BR,
    NPC_SEQ
  } npc_sel_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0180;

  // Byte distance between sequential instructions.
  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack with a saturating entry count.
// A push when full overwrites the oldest entry. A push and pop in the same
// cycle replaces the top. A pop compares the top against the supplied
// target and raises a registered one-cycle mismatch flag. The caller
// qualifies push/pop, so they are only asserted on cycles that advance.
module ras_stack #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  input  logic [XLEN-1:0] cmp_data,
  output logic            empty,
  output logic            full,
  output logic            mismatch
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   ptr;    // index of the top entry while count > 0
  logic [CW-1:0]   count;

  assign empty = (count == '0);
  assign full  = (count == CW'(RAS_DEPTH));

  // A pop only has an effect (and a comparison) when there is an entry.
  logic pop_valid;
  assign pop_valid = pop && !empty;

  // Pointer, count and mismatch flag; reset clears the occupancy only.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      ptr      <= '0;
      count    <= '0;
      mismatch <= 1'b0;
    end else begin
      mismatch <= pop_valid && (mem[ptr] != cmp_data);
      if (push && pop) begin
        if (empty) count <= CW'(1);
      end else if (push) begin
        ptr <= ptr + PW'(1);
        if (!full) count <= count + CW'(1);
      end else if (pop_valid) begin
        ptr   <= ptr - PW'(1);
        count <= count - CW'(1);
      end
    end
  end

  // Entry storage: replace the top on push+pop, else write above the top.
  always_ff @(posedge clk) begin
    // NOTE: the entry array is deliberately not reset; the count alone
    // decides which entries are valid, so stale contents are harmless.
    if (!rst && push) begin
      if (pop) mem[ptr] <= push_data;
      else     mem[ptr + PW'(1)] <= push_data;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: architectural program counter with fixed-priority next-PC
// selection (reset, exception, stall, jump, branch, sequential).
// Define PC_RAS_EN to build the return-address stack (ras_stack) that
// tracks call return addresses and flags return-target mismatches; without
// it the ras_* outputs are tied off and call_i/ret_i are ignored.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(DEFAULT_EXC_VECTOR),
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            exc_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_target_i,
  input  logic            call_i,
  input  logic            ret_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            ras_empty_o,
  output logic            ras_full_o,
  output logic            ras_mismatch_o
);

  npc_sel_e        sel;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_next;

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_q + XLEN'(PC_INC);  // wraps modulo 2^XLEN

  // Resolve the next-PC source in fixed priority order.
  always_comb begin
    // NOTE: every combinational output gets a default before the branches,
    // so no path leaves it unassigned and no latch is inferred.
    sel = NPC_SEQ;
    if (rst)             sel = NPC_RST;
    else if (exc_i)      sel = NPC_EXC;
    else if (stall_i)    sel = NPC_HOLD;
    else if (jump_i)     sel = NPC_JMP;
    else if (br_taken_i) sel = NPC_BR;
  end

  // Next-PC mux; targets are taken exactly as supplied.
  always_comb begin
    pc_next = pc_plus4_o;
    unique case (sel)
      NPC_RST:  pc_next = RESET_VECTOR;
      NPC_EXC:  pc_next = EXC_VECTOR;
      NPC_HOLD: pc_next = pc_q;
      NPC_JMP:  pc_next = jump_target_i;
      NPC_BR:   pc_next = br_target_i;
      NPC_SEQ:  pc_next = pc_plus4_o;
      default:  pc_next = pc_plus4_o;
    endcase
  end

  // PC register; reset is folded into the select as NPC_RST.
  always_ff @(posedge clk) begin
    pc_q <= pc_next;
  end

`ifdef PC_RAS_EN
  // The stack only moves on an advancing jump, which is exactly NPC_JMP.
  logic ras_push;
  logic ras_pop;
  assign ras_push = (sel == NPC_JMP) && call_i;
  assign ras_pop  = (sel == NPC_JMP) && ret_i;

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus4_o),
    .cmp_data  (jump_target_i),
    .empty     (ras_empty_o),
    .full      (ras_full_o),
    .mismatch  (ras_mismatch_o)
  );
`else
  assign ras_empty_o    = 1'b1;
  assign ras_full_o     = 1'b0;
  assign ras_mismatch_o = 1'b0;

  // Call/return hints have no consumer without the stack.
  logic unused_ras_hints;
  assign unused_ras_hints = call_i ^ ret_i;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed plus randomized checks of pc_unit against a
// queue-based reference model of the next-PC and return-address rules.
// Works for both builds; define PC_RAS_EN to exercise the stack.
module tb_pc_unit;

  localparam int unsigned  DEPTH = 4;
  localparam logic [31:0]  RV    = 32'h0000_0000;
  localparam logic [31:0]  EV    = 32'h0000_0180;
`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall_i, exc_i, br_taken_i, jump_i, call_i, ret_i;
  logic [31:0] br_target_i, jump_target_i;
  logic [31:0] pc_o, pc_plus4_o;
  logic        ras_empty_o, ras_full_o, ras_mismatch_o;

  pc_unit #(
    .XLEN         (32),
    .RESET_VECTOR (RV),
    .EXC_VECTOR   (EV),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .exc_i          (exc_i),
    .br_taken_i     (br_taken_i),
    .br_target_i    (br_target_i),
    .jump_i         (jump_i),
    .jump_target_i  (jump_target_i),
    .call_i         (call_i),
    .ret_i          (ret_i),
    .pc_o           (pc_o),
    .pc_plus4_o     (pc_plus4_o),
    .ras_empty_o    (ras_empty_o),
    .ras_full_o     (ras_full_o),
    .ras_mismatch_o (ras_mismatch_o)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state: last entry of the queue is the stack top.
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_ras[$];
  logic        m_mis = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare all outputs.
  task automatic step(input logic r, input logic e, input logic s,
                      input logic j, input logic c, input logic rt,
                      input logic b, input logic [31:0] jt, input logic [31:0] bt);
    logic [31:0] npc;
    logic [31:0] ret_addr;
    logic [31:0] popped;
    logic        mis;
    rst = r; exc_i = e; stall_i = s; jump_i = j; call_i = c; ret_i = rt;
    br_taken_i = b; jump_target_i = jt; br_target_i = bt;

    mis      = 1'b0;
    ret_addr = m_pc + 32'd4;
    if (r) begin
      npc = RV;
      m_ras.delete();
    end else if (e) begin
      npc = EV;
    end else if (s) begin
      npc = m_pc;
    end else begin
      npc = j ? jt : (b ? bt : m_pc + 32'd4);
      if (RAS_ON && j) begin
        if (c && rt) begin
          if (m_ras.size() > 0) begin
            mis = (m_ras[m_ras.size()-1] != jt);
            m_ras[m_ras.size()-1] = ret_addr;
          end else begin
            m_ras.push_back(ret_addr);
          end
        end else if (c) begin
          m_ras.push_back(ret_addr);
          if (m_ras.size() > DEPTH) popped = m_ras.pop_front();
        end else if (rt && m_ras.size() > 0) begin
          popped = m_ras.pop_back();
          mis = (popped != jt);
        end
      end
    end
    m_pc  = npc;
    m_mis = mis;

    @(posedge clk);
    #1;
    check("pc",       pc_o,       m_pc);
    check("pc_plus4", pc_plus4_o, m_pc + 32'd4);
    check("ras_empty",    {31'b0, ras_empty_o},    {31'b0, RAS_ON ? (m_ras.size() == 0) : 1'b1});
    check("ras_full",     {31'b0, ras_full_o},     {31'b0, RAS_ON ? (m_ras.size() == DEPTH) : 1'b0});
    check("ras_mismatch", {31'b0, ras_mismatch_o}, {31'b0, m_mis});
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic jmp(input logic [31:0] t, input logic c, input logic rt);
    step(0, 0, 0, 1, c, rt, 0, t, 32'h0);
  endtask

  initial begin
    // Reset then free-running sequence 0, 4, 8, C.
    step(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    check("tp_reset_pc", pc_o, 32'h0);
    check("tp_reset_empty", {31'b0, ras_empty_o}, 32'h1);
    idle(); idle(); idle();
    check("tp_seq_c", pc_o, 32'hC);

    // Stall holds, branch then redirects; exception overrides stall.
    jmp(32'h10, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    step(0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    check("tp_stall_hold", pc_o, 32'h10);
    step(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h40);
    check("tp_branch", pc_o, 32'h40);
    step(0, 1, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    check("tp_exc_over_stall", pc_o, 32'h180);

    // Jump beats branch; call then matching return.
    jmp(32'h20, 0, 0);
    step(0, 0, 0, 1, 1, 0, 1, 32'h100, 32'h200);
    check("tp_jump_over_br", pc_o, 32'h100);
    jmp(32'h24, 0, 1);
    check("tp_ret_pc", pc_o, 32'h24);
`ifdef PC_RAS_EN
    check("tp_ret_match", {31'b0, ras_mismatch_o}, 32'h0);
    check("tp_ret_empty", {31'b0, ras_empty_o}, 32'h1);
`endif

    // Five calls into a 4-deep stack, then four matching returns.
    jmp(32'h0, 0, 0);
    for (int i = 1; i <= 5; i++) jmp(32'(i * 16), 1, 0);
`ifdef PC_RAS_EN
    check("tp_full", {31'b0, ras_full_o}, 32'h1);
`endif
    jmp(32'h44, 0, 1);
    jmp(32'h34, 0, 1);
    jmp(32'h24, 0, 1);
    jmp(32'h14, 0, 1);
`ifdef PC_RAS_EN
    check("tp_drained", {31'b0, ras_empty_o}, 32'h1);
`endif

    // Return to the wrong target pulses mismatch once; empty pop is silent.
    jmp(32'h20, 0, 0);
    jmp(32'h100, 1, 0);
    jmp(32'h80, 0, 1);
    check("tp_bad_ret_pc", pc_o, 32'h80);
`ifdef PC_RAS_EN
    check("tp_bad_ret_pulse", {31'b0, ras_mismatch_o}, 32'h1);
`endif
    idle();
    check("tp_pulse_gone", {31'b0, ras_mismatch_o}, 32'h0);
    jmp(32'h99, 0, 1);
    check("tp_empty_pop", {31'b0, ras_mismatch_o}, 32'h0);

    // Address-space wrap.
    jmp(32'hFFFF_FFFC, 0, 0);
    idle();
    check("tp_wrap", pc_o, 32'h0);

    // Randomized traffic, returns often aimed at the modelled top.
    for (int n = 0; n < 3000; n++) begin
      logic        r, e, s, j, c, rt, b;
      logic [31:0] jt, bt;
      r  = ($urandom_range(0, 99) == 0);
      e  = ($urandom_range(0, 15) == 0);
      s  = ($urandom_range(0, 4) == 0);
      j  = ($urandom_range(0, 2) == 0);
      c  = ($urandom_range(0, 2) == 0);
      rt = ($urandom_range(0, 2) == 0);
      b  = ($urandom_range(0, 1) == 0);
      bt = $urandom;
      case ($urandom_range(0, 3))
        0:       jt = $urandom;
        1:       jt = 32'hFFFF_FFFC;
        default: jt = (m_ras.size() > 0 && $urandom_range(0, 1) == 1)
                      ? m_ras[m_ras.size()-1] : {$urandom_range(0, 255), 2'b00};
      endcase
      step(r, e, s, j, c, rt, b, jt, bt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
